// File: rtl/dmem_access_seq_pkg.sv
// Shared definitions for the data-memory access sequencer: default widths,
// sequencer states and the owner tags that steer read data back to a port.
package dmem_access_seq_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BEAT2 = 1'b1
    } state_e;

    // A single-word FP access travels on the low half of f_wdata and is tagged
    // FP_LO, so FP_LO always marks the last (or only) FP read beat.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INT   = 2'd1,
        OWN_FP_HI = 2'd2,
        OWN_FP_LO = 2'd3
    } owner_e;

    function automatic logic is_fp(input owner_e tag);
        return (tag == OWN_FP_HI) || (tag == OWN_FP_LO);
    endfunction

endpackage

// File: rtl/dmem_access_seq_if.sv
// Port bundle of the sequencer: integer port, FP port and synchronous SRAM pins.
interface dmem_access_seq_if
    import dmem_access_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic                  i_req;
    logic                  i_we;
    logic [ADDR_W-1:0]     i_addr;
    logic [DATA_W-1:0]     i_wdata;
    logic                  i_gnt;
    logic                  i_rvalid;
    logic [DATA_W-1:0]     i_rdata;

    logic                  f_req;
    logic                  f_we;
    logic                  f_dbl;
    logic [ADDR_W-1:0]     f_addr;
    logic [2*DATA_W-1:0]   f_wdata;
    logic                  f_gnt;
    logic                  f_rvalid;
    logic                  f_rhi;
    logic [DATA_W-1:0]     f_rdata;
    logic                  f_done;

    logic                  CEN;
    logic                  WEN;
    logic                  OEN;
    logic [ADDR_W-1:0]     A;
    logic [DATA_W-1:0]     Data2Mem;
    logic [DATA_W-1:0]     ReadDataMem;

    modport slave (
        input  i_req, i_we, i_addr, i_wdata,
        output i_gnt, i_rvalid, i_rdata,
        input  f_req, f_we, f_dbl, f_addr, f_wdata,
        output f_gnt, f_rvalid, f_rhi, f_rdata, f_done,
        output CEN, WEN, OEN, A, Data2Mem,
        input  ReadDataMem
    );

    modport master (
        output i_req, i_we, i_addr, i_wdata,
        input  i_gnt, i_rvalid, i_rdata,
        output f_req, f_we, f_dbl, f_addr, f_wdata,
        input  f_gnt, f_rvalid, f_rhi, f_rdata, f_done,
        input  CEN, WEN, OEN, A, Data2Mem,
        output ReadDataMem
    );

endinterface

// File: rtl/dmem_rr_arb.sv
// Two-input round-robin arbiter: index 0 is the integer port, index 1 the FP port.
// Grants are combinational; the priority pointer moves on every grant.
module dmem_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       block_i,
    output logic [1:0] gnt_o
);

    logic prio_fp_q;
    logic prio_fp_d;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        gnt_o     = 2'b00;
        prio_fp_d = prio_fp_q;
        if (!rst && !block_i) begin
            if (req_i == 2'b11) begin
                gnt_o = prio_fp_q ? 2'b10 : 2'b01;
            end else begin
                gnt_o = req_i;
            end
        end
        // Whoever was served now yields priority to the other port.
        if (gnt_o != 2'b00) begin
            prio_fp_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            prio_fp_q <= 1'b0;
        end else begin
            prio_fp_q <= prio_fp_d;
        end
    end

endmodule

// File: rtl/dmem_access_seq.sv
// Shares one synchronous SRAM between an integer and an FP load/store port.
// Pins are registered one cycle after grant; read data returns one cycle later.
module dmem_access_seq
    import dmem_access_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input logic              clk,
    input logic              rst,
    dmem_access_seq_if.slave bus
);

    state_e              state_q, state_d;
    logic                cen_q, cen_d;
    logic                wen_q, wen_d;
    logic                oen_q, oen_d;
    logic [ADDR_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    owner_e              tag1_q, tag1_d;
    owner_e              tag2_q;
    logic                wdone_q, wdone_d;
    logic [ADDR_W-1:0]   b2_addr_q, b2_addr_d;
    logic [DATA_W-1:0]   b2_wdata_q, b2_wdata_d;
    logic                b2_we_q, b2_we_d;
    logic [1:0]          gnt;

    dmem_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   ({bus.f_req, bus.i_req}),
        .block_i (state_q == ST_BEAT2),
        .gnt_o   (gnt)
    );

    assign bus.i_gnt = gnt[0];
    assign bus.f_gnt = gnt[1];

    always_comb begin
        state_d    = state_q;
        cen_d      = 1'b1;
        wen_d      = 1'b1;
        oen_d      = 1'b1;
        a_d        = a_q;
        dout_d     = dout_q;
        tag1_d     = OWN_NONE;
        wdone_d    = 1'b0;
        b2_addr_d  = b2_addr_q;
        b2_wdata_d = b2_wdata_q;
        b2_we_d    = b2_we_q;

        if (state_q == ST_BEAT2) begin
            // Second beat of a double FP access; the arbiter is blocked meanwhile.
            state_d = ST_IDLE;
            cen_d   = 1'b0;
            wen_d   = ~b2_we_q;
            oen_d   = b2_we_q;
            a_d     = b2_addr_q;
            if (b2_we_q) begin
                dout_d  = b2_wdata_q;
                wdone_d = 1'b1;
            end else begin
                tag1_d  = OWN_FP_LO;
            end
        end else if (gnt[0]) begin
            cen_d = 1'b0;
            wen_d = ~bus.i_we;
            oen_d = bus.i_we;
            a_d   = bus.i_addr;
            if (bus.i_we) begin
                dout_d = bus.i_wdata;
            end else begin
                tag1_d = OWN_INT;
            end
        end else if (gnt[1]) begin
            cen_d = 1'b0;
            wen_d = ~bus.f_we;
            oen_d = bus.f_we;
            a_d   = bus.f_addr;
            if (bus.f_dbl) begin
                state_d    = ST_BEAT2;
                b2_addr_d  = bus.f_addr + ADDR_W'(1);
                b2_wdata_d = bus.f_wdata[DATA_W-1:0];
                b2_we_d    = bus.f_we;
                if (bus.f_we) begin
                    dout_d = bus.f_wdata[2*DATA_W-1:DATA_W];
                end else begin
                    tag1_d = OWN_FP_HI;
                end
            end else begin
                if (bus.f_we) begin
                    dout_d  = bus.f_wdata[DATA_W-1:0];
                    wdone_d = 1'b1;
                end else begin
                    tag1_d  = OWN_FP_LO;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cen_q      <= 1'b1;
            wen_q      <= 1'b1;
            oen_q      <= 1'b1;
            a_q        <= '0;
            dout_q     <= '0;
            tag1_q     <= OWN_NONE;
            tag2_q     <= OWN_NONE;
            wdone_q    <= 1'b0;
            b2_addr_q  <= '0;
            b2_wdata_q <= '0;
            b2_we_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cen_q      <= cen_d;
            wen_q      <= wen_d;
            oen_q      <= oen_d;
            a_q        <= a_d;
            dout_q     <= dout_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag1_q;
            wdone_q    <= wdone_d;
            b2_addr_q  <= b2_addr_d;
            b2_wdata_q <= b2_wdata_d;
            b2_we_q    <= b2_we_d;
        end
    end

    assign bus.CEN      = cen_q;
    assign bus.WEN      = wen_q;
    assign bus.OEN      = oen_q;
    assign bus.A        = a_q;
    assign bus.Data2Mem = dout_q;

    // SRAM output is valid in the cycle after the read pins; tag2 says whose it is.
    assign bus.i_rvalid = ~rst & (tag2_q == OWN_INT);
    assign bus.i_rdata  = bus.ReadDataMem;
    assign bus.f_rvalid = ~rst & is_fp(tag2_q);
    assign bus.f_rhi    = ~rst & (tag2_q == OWN_FP_HI);
    assign bus.f_rdata  = bus.ReadDataMem;
    assign bus.f_done   = ~rst & (wdone_q | (tag2_q == OWN_FP_LO));

endmodule

// File: tb/tb_dmem_access_seq.sv
// Bench for dmem_access_seq: directed corner sequences, a grant-pattern table
// and a randomized run scored against a cycle-slot reference model.
module tb_dmem_access_seq;

    localparam int AW    = 7;
    localparam int DW    = 32;
    localparam int NRAND = 600;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dmem_access_seq_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_access_seq #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous SRAM model: read data appears the cycle after the read pins.
    logic [DW-1:0] sram [0:127];
    logic [DW-1:0] sram_rd;
    assign bus.ReadDataMem = sram_rd;

    function automatic logic [DW-1:0] init_word(input int i);
        case (i)
            5:       return 32'h0000_1234;
            10:      return 32'd1;
            11:      return 32'd2;
            default: return 32'hC0DE_0000 | DW'(i);
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) sram[i] <= init_word(i);
            sram_rd <= '0;
        end else if (!bus.CEN) begin
            if (!bus.WEN)      sram[bus.A] <= bus.Data2Mem;
            else if (!bus.OEN) sram_rd     <= sram[bus.A];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_addr = '0; bus.i_wdata = '0;
        bus.f_req = 1'b0; bus.f_we = 1'b0; bus.f_dbl = 1'b0; bus.f_addr = '0; bus.f_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Grant-pattern table; losers keep requesting, as the handshake demands.
    typedef struct {
        logic i_req;
        logic f_req;
        logic exp_ig;
        logic exp_fg;
    } arb_vec_t;
    arb_vec_t vecs [10];
    int n_ir, n_fr;

    // Reference model state: each cycle owns at most one pin operation slot.
    typedef struct {
        logic          v;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            tag;   // 1 int, 2 fp first word, 3 fp last word
        logic          done;
    } pin_op_t;
    pin_op_t       slot [8];
    logic          rd_v   [8];
    int            rd_tag [8];
    logic [DW-1:0] rd_d   [8];
    logic [DW-1:0] ref_mem [0:127];
    logic          m_prio_fp;
    logic [AW-1:0] m_last_a;

    logic          i_act, f_act, ig_prev, fg_prev, eg_i, eg_f;
    logic          r_iwe, r_fwe, r_fdbl;
    logic [AW-1:0] r_ia, r_fa;
    logic [DW-1:0] r_iwd;
    logic [63:0]   r_fwd;
    pin_op_t       op;
    logic          exp_done;
    int            cs, cn, cn2;

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return AW'(127);
        return AW'($urandom_range(0, 127));
    endfunction

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0};

        do_reset();

        // Reset state with idle requesters.
        mid();
        check("reset pins", {bus.CEN, bus.WEN, bus.OEN}, 3'b111);
        check("reset A", bus.A, 0);
        check("reset Data2Mem", bus.Data2Mem, 0);
        check("reset gnt", {bus.i_gnt, bus.f_gnt}, 2'b00);
        check("reset valid/done", {bus.i_rvalid, bus.f_rvalid, bus.f_rhi, bus.f_done}, 4'b0000);
        tick();

        // Integer read of address 5.
        bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_addr = AW'(5);
        mid();
        check("int rd gnt", {bus.i_gnt, bus.f_gnt}, 2'b10);
        tick();
        idle_inputs();
        mid();
        check("int rd pins", {bus.CEN, bus.WEN, bus.OEN}, 3'b010);
        check("int rd A", bus.A, 5);
        tick();
        mid();
        check("int rd rvalid", {bus.i_rvalid, bus.f_rvalid}, 2'b10);
        check("int rd rdata", bus.i_rdata, 32'h1234);
        tick();
        mid();
        check("int rd rvalid drop", bus.i_rvalid, 1'b0);
        tick();

        // Round-robin table, starting from a fresh pointer.
        do_reset();
        n_ir = 0; n_fr = 0;
        bus.i_addr = AW'(3); bus.f_addr = AW'(20);
        for (int k = 0; k < 10; k++) begin
            bus.i_req = vecs[k].i_req;
            bus.f_req = vecs[k].f_req;
            mid();
            check($sformatf("arb[%0d] i_gnt", k), bus.i_gnt, vecs[k].exp_ig);
            check($sformatf("arb[%0d] f_gnt", k), bus.f_gnt, vecs[k].exp_fg);
            if (bus.i_rvalid) n_ir++;
            if (bus.f_rvalid) n_fr++;
            tick();
        end
        idle_inputs();
        repeat (3) begin
            mid();
            if (bus.i_rvalid) n_ir++;
            if (bus.f_rvalid) n_fr++;
            tick();
        end
        check("arb int rvalid count", n_ir, 4);
        check("arb fp rvalid count", n_fr, 5);

        // FP double write wrapping from 127 to 0, with an integer request held off.
        bus.f_req = 1'b1; bus.f_we = 1'b1; bus.f_dbl = 1'b1; bus.f_addr = AW'(127);
        bus.f_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
        mid();
        check("dblwr f_gnt", bus.f_gnt, 1'b1);
        tick();
        idle_inputs();
        bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_addr = AW'(7);
        mid();
        check("dblwr blocked i_gnt", bus.i_gnt, 1'b0);
        check("dblwr b1 pins", {bus.CEN, bus.WEN, bus.OEN}, 3'b001);
        check("dblwr b1 A", bus.A, 127);
        check("dblwr b1 data", bus.Data2Mem, 32'hAAAA_BBBB);
        check("dblwr b1 done", bus.f_done, 1'b0);
        tick();
        mid();
        check("dblwr late i_gnt", bus.i_gnt, 1'b1);
        check("dblwr b2 pins", {bus.CEN, bus.WEN, bus.OEN}, 3'b001);
        check("dblwr b2 A", bus.A, 0);
        check("dblwr b2 data", bus.Data2Mem, 32'hCCCC_DDDD);
        check("dblwr done", bus.f_done, 1'b1);
        tick();
        idle_inputs();
        mid();
        check("dblwr int pins", {bus.CEN, bus.WEN, bus.OEN}, 3'b010);
        check("dblwr int A", bus.A, 7);
        check("dblwr done drop", bus.f_done, 1'b0);
        tick();
        mid();
        check("dblwr int rvalid", bus.i_rvalid, 1'b1);
        check("dblwr int rdata", bus.i_rdata, init_word(7));
        tick();

        // FP double read of addresses 10 and 11.
        bus.f_req = 1'b1; bus.f_we = 1'b0; bus.f_dbl = 1'b1; bus.f_addr = AW'(10);
        mid();
        check("dblrd f_gnt", bus.f_gnt, 1'b1);
        tick();
        idle_inputs();
        mid();
        check("dblrd b1 pins", {bus.CEN, bus.WEN, bus.OEN}, 3'b010);
        check("dblrd b1 A", bus.A, 10);
        check("dblrd t1 f_rvalid", bus.f_rvalid, 1'b0);
        tick();
        mid();
        check("dblrd b2 A", bus.A, 11);
        check("dblrd hi valid/rhi/done", {bus.f_rvalid, bus.f_rhi, bus.f_done}, 3'b110);
        check("dblrd hi data", bus.f_rdata, 1);
        tick();
        mid();
        check("dblrd lo valid/rhi/done", {bus.f_rvalid, bus.f_rhi, bus.f_done}, 3'b101);
        check("dblrd lo data", bus.f_rdata, 2);
        tick();
        mid();
        check("dblrd after valid/rhi/done", {bus.f_rvalid, bus.f_rhi, bus.f_done}, 3'b000);
        tick();

        // Reset in the second cycle of a double read.
        bus.f_req = 1'b1; bus.f_we = 1'b0; bus.f_dbl = 1'b1; bus.f_addr = AW'(10);
        mid();
        check("rstdbl f_gnt", bus.f_gnt, 1'b1);
        tick();
        idle_inputs();
        rst = 1'b1;
        bus.i_req = 1'b1; bus.i_addr = AW'(3);
        mid();
        check("rstdbl gnt under rst", {bus.i_gnt, bus.f_gnt}, 2'b00);
        tick();
        rst = 1'b0;
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            mid();
            check($sformatf("rstdbl[%0d] pins", k), {bus.CEN, bus.WEN, bus.OEN}, 3'b111);
            check($sformatf("rstdbl[%0d] A", k), bus.A, 0);
            check($sformatf("rstdbl[%0d] fp valid/done", k), {bus.f_rvalid, bus.f_done}, 2'b00);
            tick();
        end
        bus.i_req = 1'b1; bus.f_req = 1'b1; bus.f_dbl = 1'b0; bus.f_addr = AW'(4);
        mid();
        check("rstdbl first contended", {bus.i_gnt, bus.f_gnt}, 2'b10);
        tick();
        bus.i_req = 1'b0;
        mid();
        check("rstdbl fp next", bus.f_gnt, 1'b1);
        tick();

        // Pointer returns to the integer port on reset even when it owes the FP port.
        idle_inputs();
        bus.i_req = 1'b1;
        mid();
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.i_req = 1'b1; bus.f_req = 1'b1;
        mid();
        check("ptr reset contended", {bus.i_gnt, bus.f_gnt}, 2'b10);
        tick();

        // Randomized traffic against the slot model.
        do_reset();
        for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
        for (int i = 0; i < 8; i++) begin
            slot[i] = '{1'b0, 1'b0, '0, '0, 0, 1'b0};
            rd_v[i] = 1'b0; rd_tag[i] = 0; rd_d[i] = '0;
        end
        m_prio_fp = 1'b0; m_last_a = '0;
        i_act = 1'b0; f_act = 1'b0; ig_prev = 1'b0; fg_prev = 1'b0;
        r_iwe = 1'b0; r_fwe = 1'b0; r_fdbl = 1'b0; r_ia = '0; r_fa = '0; r_iwd = '0; r_fwd = '0;

        for (int c = 0; c < NRAND + 4; c++) begin
            cs = c % 8; cn = (c + 1) % 8; cn2 = (c + 2) % 8;
            if (i_act && ig_prev) i_act = 1'b0;
            if (f_act && fg_prev) f_act = 1'b0;
            if (!i_act && c < NRAND && $urandom_range(0, 99) < 55) begin
                i_act = 1'b1; r_iwe = 1'($urandom_range(0, 1));
                r_ia = rand_addr(); r_iwd = $urandom;
            end
            if (!f_act && c < NRAND && $urandom_range(0, 99) < 55) begin
                f_act = 1'b1; r_fwe = 1'($urandom_range(0, 1)); r_fdbl = 1'($urandom_range(0, 1));
                r_fa = rand_addr(); r_fwd = {$urandom, $urandom};
            end
            bus.i_req = i_act; bus.i_we = r_iwe; bus.i_addr = r_ia; bus.i_wdata = r_iwd;
            bus.f_req = f_act; bus.f_we = r_fwe; bus.f_dbl = r_fdbl; bus.f_addr = r_fa; bus.f_wdata = r_fwd;
            mid();

            eg_i = 1'b0; eg_f = 1'b0;
            if (!slot[cn].v) begin
                if (i_act && f_act) begin
                    if (m_prio_fp) eg_f = 1'b1; else eg_i = 1'b1;
                end else begin
                    eg_i = i_act; eg_f = f_act;
                end
            end
            if (eg_i) begin
                m_prio_fp = 1'b1;
                slot[cn] = '{1'b1, r_iwe, r_ia, r_iwd, 1, 1'b0};
            end
            if (eg_f) begin
                m_prio_fp = 1'b0;
                if (r_fdbl) begin
                    slot[cn]  = '{1'b1, r_fwe, r_fa, r_fwd[63:32], 2, 1'b0};
                    slot[cn2] = '{1'b1, r_fwe, AW'(r_fa + 1), r_fwd[31:0], 3, r_fwe};
                end else begin
                    slot[cn]  = '{1'b1, r_fwe, r_fa, r_fwd[31:0], 3, r_fwe};
                end
            end
            check($sformatf("rnd[%0d] gnt", c), {bus.i_gnt, bus.f_gnt}, {eg_i, eg_f});

            op = slot[cs];
            slot[cs].v = 1'b0;
            exp_done = 1'b0;
            if (op.v) begin
                check($sformatf("rnd[%0d] pins", c), {bus.CEN, bus.WEN, bus.OEN}, {1'b0, ~op.we, op.we});
                check($sformatf("rnd[%0d] A", c), bus.A, op.a);
                if (op.we) begin
                    check($sformatf("rnd[%0d] Data2Mem", c), bus.Data2Mem, op.d);
                    ref_mem[op.a] = op.d;
                    exp_done = op.done;
                end else begin
                    rd_v[cn] = 1'b1; rd_tag[cn] = op.tag; rd_d[cn] = ref_mem[op.a];
                end
                m_last_a = op.a;
            end else begin
                check($sformatf("rnd[%0d] idle pins", c), {bus.CEN, bus.WEN, bus.OEN}, 3'b111);
                check($sformatf("rnd[%0d] idle A", c), bus.A, m_last_a);
            end

            if (rd_v[cs] && rd_tag[cs] == 3) exp_done = 1'b1;
            check($sformatf("rnd[%0d] i_rvalid", c), bus.i_rvalid, rd_v[cs] && rd_tag[cs] == 1);
            check($sformatf("rnd[%0d] f_rvalid/rhi", c), {bus.f_rvalid, bus.f_rhi},
                  {rd_v[cs] && rd_tag[cs] >= 2, rd_v[cs] && rd_tag[cs] == 2});
            check($sformatf("rnd[%0d] f_done", c), bus.f_done, exp_done);
            if (rd_v[cs] && rd_tag[cs] == 1) check($sformatf("rnd[%0d] i_rdata", c), bus.i_rdata, rd_d[cs]);
            if (rd_v[cs] && rd_tag[cs] >= 2) check($sformatf("rnd[%0d] f_rdata", c), bus.f_rdata, rd_d[cs]);
            rd_v[cs] = 1'b0;

            ig_prev = bus.i_gnt;
            fg_prev = bus.f_gnt;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_access_seq.md
DMEM_ACCESS_SEQ -- requirements
Module: dmem_access_seq

Interface
REQ-001 SHALL have parameters ADDR_W, default 7, word address width; DATA_W, default 32, data word width.
REQ-002 SHALL have clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have i_req  in  1; i_we  in  1; i_addr  in  ADDR_W; i_wdata  in  DATA_W: integer load/store port.
REQ-005 SHALL have i_gnt  out  1; i_rvalid  out  1; i_rdata  out  DATA_W: integer port responses.
REQ-006 SHALL have f_req  in  1; f_we  in  1; f_dbl  in  1 (1=two-word access); f_addr  in  ADDR_W; f_wdata  in  2*DATA_W ([63:32] first word): FP load/store port.
REQ-007 SHALL have f_gnt  out  1; f_rvalid  out  1; f_rhi  out  1 (1=first word); f_rdata  out  DATA_W; f_done  out  1: FP port responses.
REQ-008 SHALL have CEN, WEN, OEN  out  1 each, active-low; A  out  ADDR_W; Data2Mem  out  DATA_W; ReadDataMem  in  DATA_W: synchronous SRAM.

Function
REQ-009 Requester SHALL hold req and all fields stable until gnt; gnt is a one-cycle pulse in the arbitration cycle t; fields are captured at the edge ending t.
REQ-010 Grant is combinational from req, state and pointer; no grant while state is BEAT2.
REQ-011 Both req in IDLE: round-robin via 1-bit last-grant pointer; pointer updates on every grant; after reset integer port wins first.
REQ-012 Memory pins SHALL be registered: command granted in t appears in t+1 (CEN=0; write: WEN=0, OEN=1, Data2Mem=wdata; read: WEN=1, OEN=0).
REQ-013 Read data SHALL be returned in t+2: rvalid=1, rdata=ReadDataMem combinationally, steered by registered owner tag; exactly one rvalid per read beat.
REQ-014 Single-word accesses SHALL sustain one grant per cycle, back-to-back, either port.
REQ-015 FSM states IDLE, BEAT2. IDLE->BEAT2 on f_gnt with f_dbl=1; BEAT2->IDLE unconditionally after one cycle.
REQ-016 Double access: beat 1 at A=f_addr with f_wdata[63:32], beat 2 at A=f_addr+1 modulo 2^ADDR_W (127 wraps to 0) with f_wdata[31:0]; beat-2 pins in t+2.
REQ-017 Double read: f_rvalid in t+2 with f_rhi=1, and in t+3 with f_rhi=0.
REQ-018 f_done SHALL pulse once per FP access: writes in the cycle the last beat is on the pins; reads in the cycle of the last f_rvalid.
REQ-019 Idle pins SHALL be CEN=WEN=OEN=1; A and Data2Mem hold last value.
REQ-020 i_rvalid, f_rvalid, f_done SHALL be 0 whenever no corresponding event; f_rhi=0 when f_rvalid=0.

Reset
REQ-021 On rst: state=IDLE, pointer=integer, CEN=WEN=OEN=1, A=0, Data2Mem=0, all gnt/rvalid/done=0, owner tags cleared.
REQ-022 Reset mid-operation SHALL discard in-flight beats: no pin activity, rvalid or done from pre-reset grants after rst deasserts.
REQ-023 Grants SHALL be suppressed in any cycle rst=1.

Structure
REQ-024 Shared package SHALL hold ADDR_W/DATA_W defaults, FSM state enum, and owner-tag encoding (NONE, INT, FP_HI, FP_LO).
REQ-025 One sub-module natural: dmem_rr_arb (2-input round-robin arbiter with pointer and hold/block input).

Verification
REQ-026 Int read addr 5, SRAM[5]=0x1234 -> i_gnt t, CEN=0/OEN=0/A=5 t+1, i_rvalid with 0x1234 t+2.
REQ-027 Both ports single-word reads every cycle for 4 cycles -> grants alternate INT,FP,INT,FP; no lost or duplicated rvalid.
REQ-028 FP double write addr 127, f_wdata=0xAAAA_BBBB_CCCC_DDDD -> pins A=127/0xAAAABBBB t+1, A=0/0xCCCCDDDD t+2, f_done t+2; i_req held blocked during t+1.
REQ-029 FP double read addr 10, SRAM[10]=1, SRAM[11]=2 -> f_rvalid t+2 (f_rhi=1, 1), t+3 (f_rhi=0, 2), f_done t+3.
REQ-030 rst asserted in t+1 of double read -> no beat 2 on pins, no f_rvalid or f_done; post-reset first contended grant goes to INT.
